rng_range: RTL and testbench
============================

RNG_RANGE -- requirements
Module: rng_range

Interface
REQ-001 Parameter MAX_RETRY, default 15: maximum rejected samples per result (1..255).
REQ-002 Parameter CACHE_EN, default 1: enables reuse of the threshold for a repeated bound.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port rnd_in, input, 32: raw word from the upstream LCG, a new value every cycle, no handshake.
REQ-006 Port req_valid, input, 1: request strobe.
REQ-007 Port req_ready, output, 1: block can accept a request.
REQ-008 Port req_bound, input, 32: exclusive upper bound N; 0 means the full 32-bit range.
REQ-009 Port out_valid, output, 1: result valid.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port out_value, output, 32: uniform result in [0, N).
REQ-012 Port out_retries, output, 8: number of rejections consumed for this result.
REQ-013 Port out_forced, output, 1: result was accepted only because MAX_RETRY was exhausted.

Function
REQ-014 The FSM SHALL have four states: IDLE, DIV, SAMPLE and OUT; req_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, req_valid&&req_ready SHALL latch req_bound and clear the retry counter.
- Next state is SAMPLE if bound==0 or on a cache hit.
- Otherwise next state is DIV.
REQ-016 Cache hit SHALL be: CACHE_EN=1, cache valid, and latched bound equal to the cached bound.
REQ-017 DIV SHALL compute t = (2^32 - N) mod N, which equals 2^32 mod N.
- Restoring division, one quotient bit per cycle, exactly 32 cycles.
- Then store t and N in the cache, set cache valid, and go to SAMPLE.
REQ-018 Each SAMPLE cycle SHALL compute the 64-bit product m = rnd_in * N and take l = m[31:0].
- Accept if l >= t: register out_value = m[63:32] and go to OUT.
- Otherwise reject: increment retries and stay in SAMPLE, using the next cycle's rnd_in.
REQ-019 When bound==0, SAMPLE SHALL accept unconditionally, with out_value = rnd_in and retries 0.
REQ-020 When retries == MAX_RETRY, the next sample SHALL be accepted regardless of l.
- out_forced = 1 only if that sample would otherwise have been rejected.
REQ-021 In OUT, out_valid SHALL be 1 and out_value/out_retries/out_forced SHALL be held stable.
- On out_ready, go to IDLE.
- out_ready is ignored in every other state.
REQ-022 Latency from request handshake at cycle H to out_valid:
- Cache hit or bound 0: out_valid at H+2 for zero rejections.
- Cache miss: out_valid at H+34.
- Each rejection adds 1 cycle.
REQ-023 N=1 SHALL yield t=0 and out_value=0 on the first sample.
REQ-024 req_valid outside IDLE SHALL be ignored, with no queuing.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL go to IDLE from any state, including mid-DIV or in OUT with out_valid high.
REQ-026 Reset SHALL clear: out_valid=0, out_value=0, out_retries=0, out_forced=0, cache valid=0.
REQ-027 After reset, req_ready SHALL be 1 in the first cycle rst is low.

Verification
REQ-028 bound=10 (cold), rnd_in=0x80000000 on the first SAMPLE cycle and 0x80000001 on the next -> first sample rejected (l=0 < t=6); out_value=5, out_retries=1, out_forced=0, out_valid at H+35.
REQ-029 bound=7 (cold), rnd_in=0xFFFFFFFF -> t=4, l=0xFFFFFFF9 accepted; out_value=6 at H+34; an immediate second request with bound=7 -> out_valid at H'+2 (cache hit).
REQ-030 bound=0, rnd_in=0xDEADBEEF -> out_value=0xDEADBEEF at H+2; bound=1 (cold) -> out_value=0 at H+34.
REQ-031 MAX_RETRY=2, bound=10, rnd_in held at 0x80000000 -> two rejections, then forced accept; out_value=5, out_retries=2, out_forced=1.
REQ-032 out_ready held low for 5 cycles in OUT -> outputs stable, req_ready=0, a req_valid pulse is ignored; rst asserted mid-DIV -> IDLE next cycle, and the next bound=7 request takes the miss path (H+34).

Source files
------------

// File: rtl/rng_range.sv
// Bounded uniform random number generator: maps a raw 32-bit word into [0, N) by
// multiply-and-reject, with a one-entry cache of the rejection threshold.
module rng_range #(
  parameter int unsigned MAX_RETRY = 15,
  parameter bit          CACHE_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rnd_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_bound,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_value,
  output logic [7:0]  out_retries,
  output logic        out_forced
);

  localparam int unsigned W  = 32;
  localparam int unsigned RW = 8;
  localparam int unsigned CW = 5;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIV    = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  bound_q, bound_d;
  logic [W-1:0]  thr_q, thr_d;
  logic [W-1:0]  cbound_q, cbound_d;
  logic          cvld_q, cvld_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          ready_q, ready_d;
  logic          oval_q, oval_d;
  logic [W-1:0]  oval_value_q, oval_value_d;
  logic [RW-1:0] oretry_q, oretry_d;
  logic          oforced_q, oforced_d;

  logic [2*W-1:0] prod;
  logic [W:0]     rem_sh;
  logic [W:0]     rem_sub;
  logic           rem_geq;
  logic           hit;

  // Next-state, datapath and output computation
  always_comb begin
    state_d      = state_q;
    bound_d      = bound_q;
    thr_d        = thr_q;
    cbound_d     = cbound_q;
    cvld_d       = cvld_q;
    rem_d        = rem_q;
    dvd_d        = dvd_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    oval_d       = oval_q;
    oval_value_d = oval_value_q;
    oretry_d     = oretry_q;
    oforced_d    = oforced_q;

    prod    = (2*W)'(rnd_in) * (2*W)'(bound_q);
    rem_sh  = {rem_q, dvd_q[W-1]};
    rem_sub = rem_sh - {1'b0, bound_q};
    rem_geq = rem_sh >= {1'b0, bound_q};
    hit     = CACHE_EN && cvld_q && (req_bound == cbound_q);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          bound_d = req_bound;
          retry_d = '0;
          if (req_bound == '0 || hit) begin
            state_d = S_SAMPLE;
          end else begin
            state_d = S_DIV;
            rem_d   = '0;
            dvd_d   = W'(0) - req_bound;
            cnt_d   = '0;
          end
        end
      end
      S_DIV: begin
        // Restoring division of (2^32 - N) by N; only the remainder is kept
        rem_d = rem_geq ? rem_sub[W-1:0] : rem_sh[W-1:0];
        dvd_d = {dvd_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          thr_d    = rem_geq ? rem_sub[W-1:0] : rem_sh[W-1:0];
          cbound_d = bound_q;
          cvld_d   = 1'b1;
          state_d  = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (bound_q == '0) begin
          oval_value_d = rnd_in;
          oretry_d     = '0;
          oforced_d    = 1'b0;
          oval_d       = 1'b1;
          state_d      = S_OUT;
        end else if (prod[W-1:0] >= thr_q || retry_q == RW'(MAX_RETRY)) begin
          oval_value_d = prod[2*W-1:W];
          oretry_d     = retry_q;
          oforced_d    = prod[W-1:0] < thr_q;
          oval_d       = 1'b1;
          state_d      = S_OUT;
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end
      default: begin
        if (out_ready) begin
          oval_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bound_q      <= '0;
      thr_q        <= '0;
      cbound_q     <= '0;
      cvld_q       <= 1'b0;
      rem_q        <= '0;
      dvd_q        <= '0;
      cnt_q        <= '0;
      retry_q      <= '0;
      ready_q      <= 1'b1;
      oval_q       <= 1'b0;
      oval_value_q <= '0;
      oretry_q     <= '0;
      oforced_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bound_q      <= bound_d;
      thr_q        <= thr_d;
      cbound_q     <= cbound_d;
      cvld_q       <= cvld_d;
      rem_q        <= rem_d;
      dvd_q        <= dvd_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      ready_q      <= ready_d;
      oval_q       <= oval_d;
      oval_value_q <= oval_value_d;
      oretry_q     <= oretry_d;
      oforced_q    <= oforced_d;
    end
  end

  assign req_ready   = ready_q;
  assign out_valid   = oval_q;
  assign out_value   = oval_value_q;
  assign out_retries = oretry_q;
  assign out_forced  = oforced_q;

endmodule

// File: tb/tb_rng_range.sv
// Bench for rng_range: directed and random requests on two instances (default
// retry limit and MAX_RETRY=2), checked against an arithmetic reference model.
module tb_rng_range;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rnd_in;
  logic [31:0] req_bound;
  logic        req_valid   [2];
  logic        out_ready   [2];
  logic        req_ready   [2];
  logic        out_valid   [2];
  logic        out_forced  [2];
  logic [31:0] out_value   [2];
  logic [7:0]  out_retries [2];

  int nvec = 0;
  int nerr = 0;

  // Reference model state: cached bound per instance and retry limits
  bit          cvld_m [2];
  logic [31:0] cb_m   [2];
  int          mr_m   [2];
  logic [31:0] dir_q  [$];

  always #5 clk = ~clk;

  rng_range u_dut0 (
    .clk(clk), .rst(rst), .rnd_in(rnd_in),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_bound(req_bound),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_value(out_value[0]),
    .out_retries(out_retries[0]), .out_forced(out_forced[0])
  );

  rng_range #(.MAX_RETRY(2), .CACHE_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .rnd_in(rnd_in),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_bound(req_bound),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_value(out_value[1]),
    .out_retries(out_retries[1]), .out_forced(out_forced[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int d, input logic [31:0] b, input int hold);
    logic        hit;
    logic        acc;
    logic        frc;
    logic [63:0] t;
    logic [63:0] m;
    logic [31:0] nr;
    logic [31:0] ev;
    int          rt;
    chk("ready_before_req", 64'(req_ready[d]), 64'd1);
    req_bound   = b;
    req_valid[d] = 1'b1;
    step();
    req_valid[d] = 1'b0;
    req_bound    = $urandom;
    hit = (b != 32'd0) && cvld_m[d] && (cb_m[d] == b);
    if (b != 32'd0 && !hit) begin
      for (int i = 0; i < 32; i++) begin
        chk("busy_div", 64'({out_valid[d], req_ready[d]}), 64'd0);
        rnd_in = $urandom;
        step();
      end
      cvld_m[d] = 1'b1;
      cb_m[d]   = b;
    end
    t   = (b == 32'd0) ? 64'd0 : (64'h1_0000_0000 % {32'd0, b});
    rt  = 0;
    acc = 1'b0;
    frc = 1'b0;
    ev  = 32'd0;
    while (!acc) begin
      chk("busy_sample", 64'({out_valid[d], req_ready[d]}), 64'd0);
      nr = (dir_q.size() != 0) ? dir_q.pop_front() : 32'($urandom);
      rnd_in = nr;
      if (b == 32'd0) begin
        acc = 1'b1;
        ev  = nr;
      end else begin
        m = {32'd0, nr} * {32'd0, b};
        if (m[31:0] >= t[31:0]) begin
          acc = 1'b1;
          ev  = m[63:32];
        end else if (rt == mr_m[d]) begin
          acc = 1'b1;
          frc = 1'b1;
          ev  = m[63:32];
        end else begin
          rt++;
        end
      end
      step();
    end
    chk("out_valid", 64'(out_valid[d]), 64'd1);
    chk("out_value", 64'(out_value[d]), 64'(ev));
    chk("out_retries", 64'(out_retries[d]), 64'(rt));
    chk("out_forced", 64'(out_forced[d]), 64'(frc));
    chk("ready_in_out", 64'(req_ready[d]), 64'd0);
    // Stall the consumer; a stray request in OUT must be dropped
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        req_valid[d] = 1'b1;
        req_bound    = $urandom;
      end
      step();
      req_valid[d] = 1'b0;
      chk("hold_stable", {out_valid[d], req_ready[d], out_forced[d], out_retries[d], 1'b0, out_value[d]},
          {1'b1, 1'b0, frc, 8'(rt), 1'b0, ev});
    end
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    chk("back_to_idle", 64'({out_valid[d], req_ready[d]}), 64'd1);
  endtask

  initial begin
    logic [31:0] b;
    mr_m[0] = 15;
    mr_m[1] = 2;
    cvld_m[0] = 1'b0;
    cvld_m[1] = 1'b0;
    cb_m[0] = 32'd0;
    cb_m[1] = 32'd0;
    rst = 1'b1;
    rnd_in = 32'd0;
    req_bound = 32'd0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    step();
    step();
    chk("rst_outputs", {out_valid[0], out_forced[0], out_retries[0], out_value[0]}, 64'd0);
    rst = 1'b0;
    chk("rst_ready0", 64'(req_ready[0]), 64'd1);
    chk("rst_ready1", 64'(req_ready[1]), 64'd1);

    // Full-range pass-through
    dir_q.push_back(32'hDEADBEEF);
    do_req(0, 32'd0, 0);
    // Cold bound 10, one rejection then accept (value 5, retries 1)
    dir_q.push_back(32'h80000000);
    dir_q.push_back(32'h80000001);
    do_req(0, 32'd10, 0);
    // Cold bound 7 then a cache hit
    dir_q.push_back(32'hFFFFFFFF);
    do_req(0, 32'd7, 0);
    do_req(0, 32'd7, 0);
    do_req(0, 32'd1, 0);
    // Retry limit exhaustion on the MAX_RETRY=2 instance
    dir_q.push_back(32'h80000000);
    dir_q.push_back(32'h80000000);
    dir_q.push_back(32'h80000000);
    do_req(1, 32'd10, 0);
    do_req(0, 32'd5, 5);

    // Reset mid-division must also drop the cached threshold for 7
    req_bound    = 32'd9;
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_div", 64'({out_valid[0], req_ready[0], req_ready[1]}), 64'd3);
    cvld_m[0] = 1'b0;
    cvld_m[1] = 1'b0;
    do_req(0, 32'd7, 0);

    for (int k = 0; k < 24; k++) begin
      case ($urandom % 7)
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'd7;
        3: b = 32'd10;
        4: b = 32'hFFFFFFFF;
        5: b = 32'h80000001;
        default: b = $urandom;
      endcase
      do_req(int'($urandom % 2), b, int'($urandom % 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
